// File: rtl/uart_cfg_report_ctrl.sv
// Report sequencer: streams "CFG=XX\r\n" for the current config byte into uart_tx,
// triggered by request, periodic timer or config change.
module uart_cfg_report_ctrl #(
    parameter int unsigned PERIOD = 11520,
    parameter int unsigned ACK_TO = 16
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic [7:0] cfgByte,
    input  logic       reportReq,
    input  logic       autoEn,
    input  logic       chgEn,
    input  logic       txBusy,
    output logic       txStart,
    output logic [7:0] txData8,
    output logic       reportBusy,
    output logic       reportDone,
    output logic       ackErr
);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_ACK, WAIT_DONE, NEXT} state_t;

    localparam logic [23:0] TIMER_LAST = 24'(PERIOD - 1);
    localparam logic [7:0]  ACK_LAST   = 8'(ACK_TO - 1);

    state_t      state_reg;
    logic [23:0] timer_reg;
    logic [7:0]  ack_cnt_reg;
    logic [2:0]  index_reg;
    logic [7:0]  last_val_reg;
    logic [7:0]  snapshot_reg;
    logic        pending_reg;

    logic timer_wrap;
    logic chg_trig;
    logic trigger;

    function automatic logic [7:0] hex_digit(input logic [3:0] n);
        return (n <= 4'd9) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
    endfunction

    function automatic logic [7:0] report_byte(input logic [2:0] idx, input logic [7:0] snap);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'h43;
            3'd1:    b = 8'h46;
            3'd2:    b = 8'h47;
            3'd3:    b = 8'h3D;
            3'd4:    b = hex_digit(snap[7:4]);
            3'd5:    b = hex_digit(snap[3:0]);
            3'd6:    b = 8'h0D;
            default: b = 8'h0A;
        endcase
        return b;
    endfunction

    assign timer_wrap = autoEn && (timer_reg == TIMER_LAST);
    // Change detection is only armed while idle so a mid-report change queues exactly one follow-up.
    assign chg_trig   = chgEn && (cfgByte != last_val_reg) && (state_reg == IDLE);
    assign trigger    = reportReq || timer_wrap || chg_trig;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            timer_reg <= '0;
        end else if (!autoEn || timer_wrap) begin
            timer_reg <= '0;
        end else begin
            timer_reg <= timer_reg + 24'd1;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_reg    <= IDLE;
            txStart      <= 1'b0;
            txData8      <= 8'h00;
            reportBusy   <= 1'b0;
            reportDone   <= 1'b0;
            ackErr       <= 1'b0;
            pending_reg  <= 1'b0;
            index_reg    <= 3'd0;
            ack_cnt_reg  <= 8'd0;
            last_val_reg <= 8'h00;
            snapshot_reg <= 8'h00;
        end else begin
            txStart    <= 1'b0;
            reportDone <= 1'b0;
            if (trigger)   pending_reg <= 1'b1;
            if (reportReq) ackErr      <= 1'b0;
            case (state_reg)
                IDLE: if (pending_reg) state_reg <= LOAD;
                LOAD: begin
                    snapshot_reg <= cfgByte;
                    last_val_reg <= cfgByte;
                    pending_reg  <= trigger;
                    index_reg    <= 3'd0;
                    reportBusy   <= 1'b1;
                    // Data and start are registered on entry so both are valid during START.
                    txData8      <= report_byte(3'd0, cfgByte);
                    txStart      <= 1'b1;
                    state_reg    <= START;
                end
                START: begin
                    ack_cnt_reg <= 8'd0;
                    state_reg   <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (txBusy) begin
                        state_reg <= WAIT_DONE;
                    end else if (ack_cnt_reg == ACK_LAST) begin
                        ackErr     <= 1'b1;
                        reportBusy <= 1'b0;
                        state_reg  <= IDLE;
                    end else begin
                        ack_cnt_reg <= ack_cnt_reg + 8'd1;
                    end
                end
                WAIT_DONE: if (!txBusy) state_reg <= NEXT;
                NEXT: begin
                    if (index_reg != 3'd7) begin
                        index_reg <= index_reg + 3'd1;
                        txData8   <= report_byte(index_reg + 3'd1, snapshot_reg);
                        txStart   <= 1'b1;
                        state_reg <= START;
                    end else begin
                        reportDone <= 1'b1;
                        reportBusy <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cfg_report_ctrl.sv
// Directed bench for uart_cfg_report_ctrl with a simple uart_tx busy model.
module tb_uart_cfg_report_ctrl;

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic [7:0] cfgByte = 8'h00;
    logic       reportReq = 1'b0;
    logic       autoEn = 1'b0;
    logic       chgEn = 1'b0;
    logic       txBusy = 1'b0;
    logic       txStart;
    logic [7:0] txData8;
    logic       reportBusy;
    logic       reportDone;
    logic       ackErr;

    int n_cmp = 0;
    int n_err = 0;

    logic model_en = 1'b1;
    int   busy_left = 0;

    logic [7:0] byte_log[$];
    int         start_stamp[$];
    int         start_cnt = 0;
    int         done_cnt = 0;
    int         viol_cnt = 0;
    int         cyc = 0;

    uart_cfg_report_ctrl #(.PERIOD(2000), .ACK_TO(16)) dut (
        .clk(clk), .nRst(nRst), .cfgByte(cfgByte), .reportReq(reportReq),
        .autoEn(autoEn), .chgEn(chgEn), .txBusy(txBusy), .txStart(txStart),
        .txData8(txData8), .reportBusy(reportBusy), .reportDone(reportDone),
        .ackErr(ackErr)
    );

    always #5 clk = ~clk;

    // uart_tx model: busy rises one cycle after start and lasts 10 cycles
    always @(posedge clk) begin
        if (busy_left != 0) begin
            busy_left <= busy_left - 1;
            txBusy    <= (busy_left > 1);
        end else if (model_en && txStart) begin
            txBusy    <= 1'b1;
            busy_left <= 10;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (txStart) begin
            byte_log.push_back(txData8);
            start_cnt <= start_cnt + 1;
            if (txData8 == 8'h43) start_stamp.push_back(cyc);
            if (txBusy) viol_cnt <= viol_cnt + 1;
        end
        if (reportDone) done_cnt <= done_cnt + 1;
    end

    function automatic logic [7:0] get_byte(input int idx);
        if (idx < byte_log.size()) return byte_log[idx];
        return 8'hxx;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_req();
        @(negedge clk) reportReq = 1'b1;
        @(negedge clk) reportReq = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (done_cnt < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (done_cnt < target) begin
            n_err++;
            $display("FAIL wait_done: got %0d reportDone pulses, expected %0d within %0d cycles", done_cnt, target, budget);
        end
    endtask

    task automatic test_reset();
        nRst = 1'b0;
        tick(3);
        n_cmp += 5;
        if (txStart !== 1'b0)    begin n_err++; $display("FAIL reset_txStart: got %b expected 0", txStart); end
        if (txData8 !== 8'h00)   begin n_err++; $display("FAIL reset_txData8: got %h expected 00", txData8); end
        if (reportBusy !== 1'b0) begin n_err++; $display("FAIL reset_reportBusy: got %b expected 0", reportBusy); end
        if (reportDone !== 1'b0) begin n_err++; $display("FAIL reset_reportDone: got %b expected 0", reportDone); end
        if (ackErr !== 1'b0)     begin n_err++; $display("FAIL reset_ackErr: got %b expected 0", ackErr); end
        nRst = 1'b1;
        tick(2);
        $display("test_reset: done");
    endtask

    task automatic test_basic();
        logic [7:0] exp_b[8];
        int b, s, d;
        exp_b = '{8'h43, 8'h46, 8'h47, 8'h3D, 8'h35, 8'h41, 8'h0D, 8'h0A};
        cfgByte = 8'h5A;
        b = byte_log.size(); s = start_cnt; d = done_cnt;
        pulse_req();
        wait_done(d + 1, 400);
        tick(20);
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (get_byte(b + i) !== exp_b[i]) begin
                n_err++;
                $display("FAIL basic_byte%0d: got %h expected %h", i, get_byte(b + i), exp_b[i]);
            end
        end
        n_cmp += 4;
        if (start_cnt - s !== 8) begin n_err++; $display("FAIL basic_starts: got %0d expected 8", start_cnt - s); end
        if (done_cnt - d !== 1)  begin n_err++; $display("FAIL basic_done: got %0d expected 1", done_cnt - d); end
        if (reportBusy !== 1'b0) begin n_err++; $display("FAIL basic_busy: got %b expected 0", reportBusy); end
        if (txData8 !== 8'h0A)   begin n_err++; $display("FAIL basic_hold: got %h expected 0a", txData8); end
        $display("test_basic: cfg=5a bytes logged=%0d", byte_log.size() - b);
    endtask

    task automatic test_digits();
        logic [7:0] cfg_t[2];
        logic [7:0] hi_t[2];
        logic [7:0] lo_t[2];
        int b, d;
        cfg_t = '{8'h09, 8'hF0};
        hi_t  = '{8'h30, 8'h46};
        lo_t  = '{8'h39, 8'h30};
        for (int t = 0; t < 2; t++) begin
            cfgByte = cfg_t[t];
            b = byte_log.size(); d = done_cnt;
            pulse_req();
            wait_done(d + 1, 400);
            tick(5);
            n_cmp += 2;
            if (get_byte(b + 4) !== hi_t[t]) begin n_err++; $display("FAIL digit_hi_%h: got %h expected %h", cfg_t[t], get_byte(b + 4), hi_t[t]); end
            if (get_byte(b + 5) !== lo_t[t]) begin n_err++; $display("FAIL digit_lo_%h: got %h expected %h", cfg_t[t], get_byte(b + 5), lo_t[t]); end
            $display("test_digits: cfg=%h digits %h %h", cfg_t[t], get_byte(b + 4), get_byte(b + 5));
        end
    endtask

    task automatic test_back_to_back();
        int s, d;
        cfgByte = 8'h3C;
        s = start_cnt; d = done_cnt;
        pulse_req();
        tick(20);
        repeat (3) begin
            pulse_req();
            tick(5);
        end
        wait_done(d + 2, 600);
        tick(300);
        n_cmp += 3;
        if (done_cnt - d !== 2)   begin n_err++; $display("FAIL b2b_done: got %0d expected 2", done_cnt - d); end
        if (start_cnt - s !== 16) begin n_err++; $display("FAIL b2b_starts: got %0d expected 16", start_cnt - s); end
        if (reportBusy !== 1'b0)  begin n_err++; $display("FAIL b2b_busy: got %b expected 0", reportBusy); end
        $display("test_back_to_back: reports=%0d", done_cnt - d);
    endtask

    task automatic test_change();
        int b, s, d, k;
        b = byte_log.size(); s = start_cnt; d = done_cnt;
        @(negedge clk);
        cfgByte = 8'h11;
        chgEn = 1'b1;
        k = 0;
        while (start_cnt < s + 3 && k < 200) begin
            @(negedge clk);
            k++;
        end
        cfgByte = 8'h22;
        wait_done(d + 2, 600);
        tick(300);
        n_cmp += 6;
        if (get_byte(b + 4) !== 8'h31)  begin n_err++; $display("FAIL chg_first_hi: got %h expected 31", get_byte(b + 4)); end
        if (get_byte(b + 5) !== 8'h31)  begin n_err++; $display("FAIL chg_first_lo: got %h expected 31", get_byte(b + 5)); end
        if (get_byte(b + 12) !== 8'h32) begin n_err++; $display("FAIL chg_second_hi: got %h expected 32", get_byte(b + 12)); end
        if (get_byte(b + 13) !== 8'h32) begin n_err++; $display("FAIL chg_second_lo: got %h expected 32", get_byte(b + 13)); end
        if (done_cnt - d !== 2)         begin n_err++; $display("FAIL chg_done: got %0d expected 2", done_cnt - d); end
        if (start_cnt - s !== 16)       begin n_err++; $display("FAIL chg_starts: got %0d expected 16", start_cnt - s); end
        chgEn = 1'b0;
        $display("test_change: reports=%0d", done_cnt - d);
    endtask

    task automatic test_auto();
        int st, d, cyc0, first, second;
        cfgByte = 8'h77;
        @(negedge clk);
        st = start_stamp.size(); d = done_cnt; cyc0 = cyc;
        autoEn = 1'b1;
        tick(4500);
        first  = (start_stamp.size() > st)     ? start_stamp[st]     : -1;
        second = (start_stamp.size() > st + 1) ? start_stamp[st + 1] : -1;
        n_cmp += 3;
        if (done_cnt - d !== 2)        begin n_err++; $display("FAIL auto_done: got %0d expected 2", done_cnt - d); end
        if (first - cyc0 !== 2002)     begin n_err++; $display("FAIL auto_first: got %0d expected 2002", first - cyc0); end
        if (second - first !== 2000)   begin n_err++; $display("FAIL auto_interval: got %0d expected 2000", second - first); end
        autoEn = 1'b0;
        d = done_cnt;
        tick(4500);
        n_cmp++;
        if (done_cnt - d !== 0) begin n_err++; $display("FAIL auto_off: got %0d expected 0", done_cnt - d); end
        $display("test_auto: interval=%0d", second - first);
    endtask

    task automatic test_ack_timeout();
        int s, k;
        model_en = 1'b0;
        tick(2);
        s = start_cnt;
        @(negedge clk) reportReq = 1'b1;
        @(negedge clk) reportReq = 1'b0;
        k = 0;
        while (!ackErr && k < 100) begin
            @(negedge clk);
            k++;
        end
        tick(10);
        n_cmp += 4;
        if (k !== 19)            begin n_err++; $display("FAIL ack_latency: got %0d expected 19", k); end
        if (ackErr !== 1'b1)     begin n_err++; $display("FAIL ack_err: got %b expected 1", ackErr); end
        if (start_cnt - s !== 1) begin n_err++; $display("FAIL ack_starts: got %0d expected 1", start_cnt - s); end
        if (reportBusy !== 1'b0) begin n_err++; $display("FAIL ack_busy: got %b expected 0", reportBusy); end
        model_en = 1'b1;
        $display("test_ack_timeout: ackErr after %0d cycles", k);
    endtask

    task automatic test_reset_mid();
        int s;
        cfgByte = 8'hA5;
        pulse_req();
        tick(30);
        n_cmp += 2;
        if (ackErr !== 1'b0)     begin n_err++; $display("FAIL mid_ackclr: got %b expected 0", ackErr); end
        if (reportBusy !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b expected 1", reportBusy); end
        @(negedge clk) nRst = 1'b0;
        #1;
        n_cmp += 4;
        if (txStart !== 1'b0)    begin n_err++; $display("FAIL mid_rst_txStart: got %b expected 0", txStart); end
        if (txData8 !== 8'h00)   begin n_err++; $display("FAIL mid_rst_txData8: got %h expected 00", txData8); end
        if (reportBusy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b expected 0", reportBusy); end
        if (reportDone !== 1'b0) begin n_err++; $display("FAIL mid_rst_done: got %b expected 0", reportDone); end
        @(negedge clk) nRst = 1'b1;
        s = start_cnt;
        tick(200);
        n_cmp += 2;
        if (start_cnt !== s)     begin n_err++; $display("FAIL mid_noresume: got %0d starts expected 0", start_cnt - s); end
        if (reportBusy !== 1'b0) begin n_err++; $display("FAIL mid_idle: got %b expected 0", reportBusy); end
        $display("test_reset_mid: done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_digits();
        test_back_to_back();
        test_change();
        test_auto();
        test_ack_timeout();
        test_reset_mid();
        n_cmp++;
        if (viol_cnt !== 0) begin n_err++; $display("FAIL start_while_busy: got %0d expected 0", viol_cnt); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_cfg_report_ctrl.md
Name: uart_cfg_report_ctrl

Overview:
Sequencer that owns the txStart/txData8 side of uart_tx and reports the current 8-bit config value as the ASCII line "CFG=XX\r\n". XX is two hex digits. A report is triggered by a request pulse, a periodic timer, or a change of the config value. The block runs in the UART bit-clock domain and sits between the config bus and uart_tx.

Parameters:
PERIOD, 11520, clk cycles between automatic reports when autoEn=1 (0.1 s at 115200 Hz); legal range 2..2^24-1.
ACK_TO, 16, clk cycles to wait for txBusy to rise after txStart before aborting; legal range 2..255.

Ports:
clk  input  1  UART bit clock, same clock as uart_tx.
nRst  input  1  asynchronous active-low reset.
cfgByte  input  8  config value to report; sampled only at report start.
reportReq  input  1  one-cycle request for a report.
autoEn  input  1  enables the periodic timer.
chgEn  input  1  enables a report when cfgByte differs from the last reported value.
txBusy  input  1  busy flag from uart_tx.
txStart  output  1  one-cycle start pulse to uart_tx.
txData8  output  8  byte to uart_tx; held stable from txStart until txBusy falls.
reportBusy  output  1  high from LOAD through the last byte's WAIT_DONE.
reportDone  output  1  one-cycle pulse when byte 7 completes.
ackErr  output  1  sticky flag, set on an ACK_TO timeout; cleared by reset or by a reportReq pulse.

Behaviour:
- Reset (async, nRst=0): state IDLE; txStart=0, txData8=0x00, reportBusy=0, reportDone=0, ackErr=0; pending=0; timer=0; byte index=0; lastVal=0x00; snapshot=0x00.
- Reset mid-report: the report is abandoned. No resume after reset release.
- Timer:
  - Counts while autoEn=1 and wraps at PERIOD-1.
  - On wrap it sets pending.
  - When autoEn=0 it holds at 0.
- reportReq sets pending.
- chgEn=1 with cfgByte!=lastVal sets pending, but only in IDLE.
- Multiple triggers while busy coalesce into a single pending report, served right after the current report finishes.
- State machine, one transition per clk:
  - IDLE: if pending -> LOAD.
  - LOAD: snapshot<=cfgByte; lastVal<=cfgByte; pending<=0; index<=0; reportBusy<=1 -> START. A trigger arriving in this same cycle re-sets pending; set wins over clear.
  - START: txData8<=byte[index]; txStart=1 for exactly this cycle; ack counter<=0 -> WAIT_ACK.
  - WAIT_ACK:
    - txBusy=1 -> WAIT_DONE.
    - Otherwise increment the ack counter; at ACK_TO-1, set ackErr, clear reportBusy -> IDLE. Pending is preserved.
  - WAIT_DONE: when txBusy=0 -> NEXT.
  - NEXT:
    - index<7: index+1 -> START.
    - index=7: reportDone=1 for one cycle, reportBusy<=0 -> IDLE.
- Byte table:
  - index 0..7 = 0x43 'C', 0x46 'F', 0x47 'G', 0x3D '=', hex(snapshot[7:4]), hex(snapshot[3:0]), 0x0D, 0x0A.
  - hex(n) = 0x30+n for n<=9, 0x41+(n-10) for n>=10 (upper case).
- txData8 keeps its last value in IDLE.
- txStart is never asserted while txBusy=1.
- Minimum spacing between starts is START, WAIT_ACK, WAIT_DONE, NEXT = 4 cycles, plus the UART frame time.
- cfgByte changing during a report does not affect the digits in flight. With chgEn=1 it triggers a new report after the current one.

Test Plan:
- cfgByte=0x5A, one reportReq pulse, uart_tx model (busy 1 cycle after start, 10 cycles long) -> txData8 sequence 43 46 47 3D 35 41 0D 0A; exactly 8 txStart pulses; one reportDone; reportBusy low afterwards.
- cfgByte=0x09, then 0xF0, one report each -> digit bytes 30 39, then 46 30.
- autoEn=1, PERIOD=2000, idle line -> a report starts every 2000 cycles; with autoEn=0 there are no further reports.
- Three reportReq pulses during one report -> exactly one extra report follows; total 2 reportDone.
- chgEn=1, cfgByte steps 0x11 -> 0x22 during byte 2 -> current report sends 31 31; the next report sends 32 32; then no further reports.
- txBusy held 0 -> after ACK_TO=16 cycles ackErr=1, state IDLE, txStart pulsed once; nRst=0 mid-report -> all outputs reset within the same cycle.
